regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port register file, successor to the CPU's 2-read/1-write register file. It keeps combinational reads and adds the following:
- N read ports and M write ports.
- Posedge writes with same-cycle write-to-read bypass.
- A hardwired zero register.
- Asynchronous reset of all storage.
- A sequential CLEAR engine, so software or the pipeline can wipe the file without asserting reset.

It sits in the decode stage and feeds operand muxes. The writeback and load-return paths drive its write ports.

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH
NUM_READ, 2, number of read ports (1..8)
NUM_WRITE, 2, number of write ports (1..4)
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads

Ports:
CLOCK  in  1  clock, all state updates on rising edge
RESET  in  1  asynchronous, active-high reset
RA  in  NUM_READ*ADDR_WIDTH  read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
RD  out  NUM_READ*DATA_WIDTH  read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
WE  in  NUM_WRITE  write enables
WA  in  NUM_WRITE*ADDR_WIDTH  write addresses, same packing as RA
WD  in  NUM_WRITE*DATA_WIDTH  write data, same packing as RD
CLEAR_REQ  in  1  start sequential clear (level sampled at posedge)
BUSY  out  1  clear engine active
DROP  out  1  registered, one-cycle pulse: a write was discarded because BUSY

Behaviour:
- Reset (asynchronous, while RESET=1):
  - all DEPTH registers = 0
  - FSM = IDLE, clear counter = 0
  - BUSY = 0, DROP = 0
  - RD reflects cleared storage, so RD = 0.
- Reads: combinational, zero latency.
  - Base value: RD[i] = REGS[RA[i]].
  - If ZERO_REG=1 and RA[i]==0: RD[i] = 0, taking priority over bypass.
  - If BYPASS=1, BUSY=0, and some port j has WE[j]=1 and WA[j]==RA[i] (excluding address 0 when ZERO_REG=1): RD[i] = WD of the highest-index matching j.
- Writes: rising edge of CLOCK, only when BUSY=0.
  - For each j with WE[j]=1: REGS[WA[j]] <= WD[j].
  - Same-address conflict: the highest-index port wins, other writes to that address are lost.
  - With ZERO_REG=1, writes to address 0 are discarded silently and DROP is not asserted.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when CLEAR_REQ=1 at posedge. Counter <= 0 and BUSY becomes 1 from the next cycle.
  - CLEAR: each posedge, REGS[counter] <= 0 and counter++. At counter==DEPTH-1, write the last entry and return to IDLE, with BUSY=0 the following cycle. CLEAR therefore lasts exactly DEPTH cycles.
  - CLEAR_REQ while BUSY=1 is ignored. There is no restart and no queueing.
  - The clear is not cancellable except by RESET.
- While BUSY=1:
  - all external writes are discarded
  - DROP <= 1 on the next cycle if any WE bit was 1, else DROP <= 0
  - bypass is disabled
  - reads return current storage, which is partially cleared
- CLEAR_REQ and WE asserted in the same IDLE cycle: the write commits (BUSY was 0), then CLEAR begins and zeroes it.
- RESET asserted mid-CLEAR: immediately returns to the reset state above.
- Counter width is ADDR_WIDTH. The DEPTH-1 comparison prevents wrap-around.

Decomposition:
- Shared package `regfile_pkg`:
  - state enum {IDLE, CLEAR}
  - localparam DEPTH
  - slice helper functions for packed port vectors
- Sub-module `regfile_wr_arb`: per-address write-select and priority resolution across NUM_WRITE ports. It is reused by the bypass logic (same highest-index rule).
- Clear FSM and storage stay in the top module.

Test Plan:
1. Reset then read: RESET=1 then 0; RA0=3, RA1=31 -> RD0=0, RD1=0, BUSY=0, DROP=0.
2. Write, then same-cycle bypass:
   - Cycle 1: WE=01, WA0=5, WD0=0xDEADBEEF.
   - Same cycle, RA0=5 -> RD0=0xDEADBEEF (bypass).
   - Next cycle, WE=0 -> RD0=0xDEADBEEF (storage).
3. Write conflict and zero register:
   - WE=11, WA0=WA1=7, WD0=0x1111, WD1=0x2222 -> REGS[7]=0x2222.
   - WE=01, WA0=0, WD0=0xFFFF -> RA=0 reads 0; DROP stays 0.
4. Clear sweep:
   - Preload regs 1..31 with their index.
   - Pulse CLEAR_REQ -> BUSY=1 for exactly 32 cycles.
   - After 16 cycles: RA=20 still reads 20 and RA=10 reads 0.
   - At end: all reads 0.
5. Write during clear: with BUSY=1, WE=01, WA0=9, WD0=0xABCD -> DROP=1 for one cycle, RD for RA=9 is not 0xABCD, and bypass is not applied.
6. Reset mid-clear: assert RESET at clear cycle 10 -> BUSY=0 asynchronously and all reads 0. After release, a CLEAR_REQ starts a fresh 32-cycle sweep.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

   // Clear engine states
   typedef enum logic [0:0] {
      IDLE,
      CLEAR
   } state_e;

   // Depth for the default 5-bit address configuration
   localparam int unsigned DEFAULT_ADDR_WIDTH = 5;
   localparam int unsigned DEPTH = 2 ** DEFAULT_ADDR_WIDTH;

   // Number of registers addressed by an address of the given width
   function automatic int unsigned depth_of(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

   // Low bit of field idx inside a packed port vector of width-bit fields
   function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
      return idx * width;
   endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Write-port priority resolution for one address: reports whether any enabled
// write port targets the address and, if so, the data of the highest-index one.
// Used both for storage updates and for read bypass so the two always agree.
module regfile_wr_arb
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned NUM_WRITE  = 2,
   parameter int unsigned ZERO_REG   = 1
) (
   input  logic [ADDR_WIDTH-1:0]           addr_i,
   input  logic [NUM_WRITE-1:0]            we_i,
   input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wa_i,
   input  logic [NUM_WRITE*DATA_WIDTH-1:0] wd_i,
   output logic                            hit_o,
   output logic [DATA_WIDTH-1:0]           data_o
);

   logic addr_blocked;

   // Register 0 never accepts writes when it is hardwired
   assign addr_blocked = (ZERO_REG != 0) && (addr_i == '0);

   // Ascending scan: a later (higher-index) match overrides earlier ones
   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      for (int unsigned j = 0; j < NUM_WRITE; j++) begin
         if (we_i[j] && !addr_blocked &&
             (wa_i[slice_lo(j, ADDR_WIDTH) +: ADDR_WIDTH] == addr_i)) begin
            hit_o  = 1'b1;
            data_o = wd_i[slice_lo(j, DATA_WIDTH) +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with combinational reads, same-cycle write bypass,
// optional hardwired zero register and a sequential clear engine.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned NUM_READ   = 2,
   parameter int unsigned NUM_WRITE  = 2,
   parameter int unsigned ZERO_REG   = 1,
   parameter int unsigned BYPASS     = 1
) (
   input  logic                            CLOCK,
   input  logic                            RESET,
   input  logic [NUM_READ*ADDR_WIDTH-1:0]  RA,
   output logic [NUM_READ*DATA_WIDTH-1:0]  RD,
   input  logic [NUM_WRITE-1:0]            WE,
   input  logic [NUM_WRITE*ADDR_WIDTH-1:0] WA,
   input  logic [NUM_WRITE*DATA_WIDTH-1:0] WD,
   input  logic                            CLEAR_REQ,
   output logic                            BUSY,
   output logic                            DROP
);

   localparam int unsigned Depth = depth_of(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] regs_q [Depth];
   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  drop_q, drop_d;
   logic                  busy;

   logic [Depth-1:0]      whit;
   logic [DATA_WIDTH-1:0] wdat [Depth];

   assign busy = (state_q == CLEAR);
   assign BUSY = busy;
   assign DROP = drop_q;

   // Per-address write resolution feeding the storage update
   for (genvar a = 0; a < Depth; a++) begin : g_wr
      regfile_wr_arb #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH),
         .NUM_WRITE  (NUM_WRITE),
         .ZERO_REG   (ZERO_REG)
      ) u_arb (
         .addr_i (ADDR_WIDTH'(a)),
         .we_i   (WE),
         .wa_i   (WA),
         .wd_i   (WD),
         .hit_o  (whit[a]),
         .data_o (wdat[a])
      );
   end

   // Read ports: zero register beats bypass, bypass beats storage
   for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      logic                  bhit;
      logic [DATA_WIDTH-1:0] bdat;
      logic [DATA_WIDTH-1:0] rd;

      assign ra = RA[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH];

      regfile_wr_arb #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH),
         .NUM_WRITE  (NUM_WRITE),
         .ZERO_REG   (ZERO_REG)
      ) u_byp (
         .addr_i (ra),
         .we_i   (WE),
         .wa_i   (WA),
         .wd_i   (WD),
         .hit_o  (bhit),
         .data_o (bdat)
      );

      // Select read data for this port
      always_comb begin
         rd = regs_q[ra];
         if ((BYPASS != 0) && !busy && bhit) begin
            rd = bdat;
         end
         if ((ZERO_REG != 0) && (ra == '0)) begin
            rd = '0;
         end
      end

      assign RD[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] = rd;
   end

   // Clear engine next state; drop flags any write attempted while busy
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      drop_d  = busy && (|WE);
      unique case (state_q)
         IDLE: begin
            if (CLEAR_REQ) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            if (cnt_q == ADDR_WIDTH'(Depth - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Clear engine state, counter and drop flag
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drop_q  <= drop_d;
      end
   end

   // Storage: the clear sweep owns the array while busy, external writes otherwise
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         for (int unsigned a = 0; a < Depth; a++) begin
            regs_q[a] <= '0;
         end
      end else begin
         for (int unsigned a = 0; a < Depth; a++) begin
            if (busy) begin
               if (cnt_q == ADDR_WIDTH'(a)) begin
                  regs_q[a] <= '0;
               end
            end else if (whit[a]) begin
               regs_q[a] <= wdat[a];
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: behavioural model plus directed checks.
module tb_regfile_mp;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NR    = 2;
   localparam int NW    = 2;
   localparam int DEPTH = 32;

   logic              CLOCK = 1'b0;
   logic              RESET = 1'b0;
   logic [NR*AW-1:0]  RA;
   logic [NR*DW-1:0]  RD;
   logic [NW-1:0]     WE;
   logic [NW*AW-1:0]  WA;
   logic [NW*DW-1:0]  WD;
   logic              CLEAR_REQ;
   logic              BUSY;
   logic              DROP;

   int errors = 0;
   int checks = 0;
   bit check_en = 1'b0;

   always #5 CLOCK = ~CLOCK;

   regfile_mp #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .NUM_READ   (NR),
      .NUM_WRITE  (NW),
      .ZERO_REG   (1),
      .BYPASS     (1)
   ) dut (
      .CLOCK     (CLOCK),
      .RESET     (RESET),
      .RA        (RA),
      .RD        (RD),
      .WE        (WE),
      .WA        (WA),
      .WD        (WD),
      .CLEAR_REQ (CLEAR_REQ),
      .BUSY      (BUSY),
      .DROP      (DROP)
   );

   // Reference model: register contents, remaining clear cycles, drop flag
   logic [DW-1:0] mregs [DEPTH];
   int            left;
   logic          mdrop;

   always @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         for (int a = 0; a < DEPTH; a++) mregs[a] <= '0;
         left  <= 0;
         mdrop <= 1'b0;
      end else begin
         mdrop <= (left > 0) && (WE != '0);
         if (left > 0) begin
            mregs[DEPTH - left] <= '0;
            left <= left - 1;
         end else begin
            for (int j = 0; j < NW; j++) begin
               if (WE[j] && (WA[j*AW +: AW] != '0)) mregs[WA[j*AW +: AW]] <= WD[j*DW +: DW];
            end
            if (CLEAR_REQ) left <= DEPTH;
         end
      end
   end

   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
      logic [DW-1:0] v;
      v = mregs[a];
      if (left == 0) begin
         for (int j = 0; j < NW; j++) begin
            if (WE[j] && (WA[j*AW +: AW] == a)) v = WD[j*DW +: DW];
         end
      end
      if (a == '0) v = '0;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Every-cycle comparison against the model
   always @(negedge CLOCK) begin
      if (check_en) begin
         chk("model_busy", DW'(BUSY), DW'(left > 0));
         chk("model_drop", DW'(DROP), DW'(mdrop));
         for (int i = 0; i < NR; i++) begin
            chk("model_rd", RD[i*DW +: DW], exp_rd(RA[i*AW +: AW]));
         end
      end
   end

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic settle();
      @(negedge CLOCK);
      #1;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 100 && BUSY; k++) tick();
      chk("idle_timeout", DW'(BUSY), 0);
   endtask

   // Counts consecutive busy cycles; optionally probes reads halfway through
   task automatic count_busy(output int n, input bit mid);
      n = 0;
      for (int k = 0; k < 100; k++) begin
         settle();
         if (!BUSY) break;
         if (mid && n == 16) begin
            chk("clear_mid_ra20", RD[0 +: DW], 20);
            chk("clear_mid_ra10", RD[DW +: DW], 0);
         end
         n++;
      end
   endtask

   task automatic write1(input int a, input logic [DW-1:0] d);
      WE = 2'b01;
      WA[0 +: AW] = AW'(a);
      WD[0 +: DW] = d;
      tick();
      WE = '0;
   endtask

   int n;

   initial begin
      RA = '0; WE = '0; WA = '0; WD = '0; CLEAR_REQ = 1'b0;
      #1 RESET = 1'b1;
      #1 check_en = 1'b1;
      repeat (2) @(posedge CLOCK);
      #1 RESET = 1'b0;

      // Reset then read
      RA[0 +: AW] = 5'd3; RA[AW +: AW] = 5'd31;
      settle();
      chk("reset_rd0", RD[0 +: DW], 0);
      chk("reset_rd1", RD[DW +: DW], 0);
      chk("reset_busy", DW'(BUSY), 0);
      chk("reset_drop", DW'(DROP), 0);
      tick();

      // Write with same-cycle bypass, then from storage
      WE = 2'b01; WA[0 +: AW] = 5'd5; WD[0 +: DW] = 32'hDEADBEEF; RA[0 +: AW] = 5'd5;
      settle();
      chk("bypass_rd0", RD[0 +: DW], 32'hDEADBEEF);
      tick();
      WE = '0;
      settle();
      chk("stored_rd0", RD[0 +: DW], 32'hDEADBEEF);
      tick();

      // Same-address conflict: higher port wins
      WE = 2'b11; WA = {5'd7, 5'd7}; WD = {32'h2222, 32'h1111}; RA[0 +: AW] = 5'd7;
      settle();
      chk("conflict_bypass", RD[0 +: DW], 32'h2222);
      tick();
      WE = '0;
      settle();
      chk("conflict_stored", RD[0 +: DW], 32'h2222);
      tick();

      // Zero register ignores writes and does not raise DROP
      WE = 2'b01; WA[0 +: AW] = 5'd0; WD[0 +: DW] = 32'hFFFF; RA[0 +: AW] = 5'd0;
      settle();
      chk("zero_bypass", RD[0 +: DW], 0);
      tick();
      WE = '0;
      settle();
      chk("zero_stored", RD[0 +: DW], 0);
      chk("zero_drop", DW'(DROP), 0);
      tick();

      // Randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         for (int j = 0; j < NW; j++) begin
            WE[j] = 1'($urandom_range(0, 1));
            WA[j*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            WD[j*DW +: DW] = $urandom;
         end
         for (int i = 0; i < NR; i++) begin
            RA[i*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
         end
         CLEAR_REQ = ($urandom_range(0, 39) == 0);
         tick();
      end
      WE = '0; CLEAR_REQ = 1'b0;
      wait_idle();
      tick();

      // Clear sweep over preloaded registers
      for (int a = 1; a < DEPTH; a++) write1(a, DW'(a));
      RA[0 +: AW] = 5'd20; RA[AW +: AW] = 5'd10;
      CLEAR_REQ = 1'b1;
      tick();
      CLEAR_REQ = 1'b0;
      count_busy(n, 1'b1);
      chk("clear_len", DW'(n), 32);
      tick();
      for (int a = 0; a < DEPTH; a += 2) begin
         RA[0 +: AW] = AW'(a); RA[AW +: AW] = AW'(a + 1);
         settle();
         chk("clear_all0", RD[0 +: DW], 0);
         chk("clear_all1", RD[DW +: DW], 0);
         tick();
      end

      // Write during clear is dropped and not bypassed
      CLEAR_REQ = 1'b1;
      tick();
      CLEAR_REQ = 1'b0;
      WE = 2'b01; WA[0 +: AW] = 5'd9; WD[0 +: DW] = 32'hABCD; RA[0 +: AW] = 5'd9;
      settle();
      chk("busy_no_bypass", RD[0 +: DW], 0);
      tick();
      WE = '0;
      settle();
      chk("busy_drop1", DWprime_drop(), 1);
      tick();
      settle();
      chk("busy_drop0", DW'(DROP), 0);
      chk("busy_not_written", RD[0 +: DW], 0);
      tick();
      wait_idle();
      tick();

      // Reset in the middle of a clear
      write1(25, 32'h55);
      RA[0 +: AW] = 5'd25; RA[AW +: AW] = 5'd3;
      CLEAR_REQ = 1'b1;
      tick();
      CLEAR_REQ = 1'b0;
      repeat (10) tick();
      chk("midclear_keep25", RD[0 +: DW], 32'h55);
      chk("midclear_busy", DW'(BUSY), 1);
      RESET = 1'b1;
      #1;
      chk("rst_busy", DW'(BUSY), 0);
      chk("rst_rd0", RD[0 +: DW], 0);
      chk("rst_rd1", RD[DW +: DW], 0);
      tick();
      RESET = 1'b0;
      CLEAR_REQ = 1'b1;
      tick();
      CLEAR_REQ = 1'b0;
      count_busy(n, 1'b0);
      chk("fresh_clear_len", DW'(n), 32);
      tick();

      check_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   function automatic logic [DW-1:0] DWprime_drop();
      return DW'(DROP);
   endfunction

endmodule
